// File: rtl/fir_sample_sequencer.sv
// rtl/fir_sample_sequencer.sv - ROM read sequencer and sample-valid strobe generator for the adaptive FIR
//
// Purpose:
//   Walks the shared mic1/mic2/mu ROM address space at a programmable rate.
//   Each ROM word set is registered and presented to the filter with a one-cycle
//   sample-valid strobe. o_out_valid marks the filter output FILTER_LAT cycles later.
//   o_done pulses when the last filter output of a run has been produced.
//
// Ports:
//   i_clk, i_rst               clock (rising edge), asynchronous active-low reset
//   i_start, i_abort           start a run (IDLE only), abandon the current run
//   i_num_samples, i_period    run length (0 = 2**NB_DEPTH), cycles per read (0 = 1)
//   o_rom_en, o_rom_addr       synchronous ROM read port (one-cycle latency)
//   i_rom_mic1/mic2/mu         ROM read data
//   o_mic1/o_mic2/o_mu         registered sample set to the filter
//   o_sample_valid             one-cycle strobe, new sample set present
//   o_out_valid                filter output valid
//   o_busy, o_done             run in progress, normal completion pulse
//   o_sample_count             strobes issued in the current/last run

module fir_sample_sequencer #(
    parameter int NB_DATA    = 21,
    parameter int NB_DEPTH   = 14,
    parameter int NB_PERIOD  = 8,
    parameter int FILTER_LAT = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [NB_DEPTH-1:0]  i_num_samples,
    input  logic [NB_PERIOD-1:0] i_period,
    output logic                 o_rom_en,
    output logic [NB_DEPTH-1:0]  o_rom_addr,
    input  logic [NB_DATA-1:0]   i_rom_mic1,
    input  logic [NB_DATA-1:0]   i_rom_mic2,
    input  logic [NB_DATA-1:0]   i_rom_mu,
    output logic [NB_DATA-1:0]   o_mic1,
    output logic [NB_DATA-1:0]   o_mic2,
    output logic [NB_DATA-1:0]   o_mu,
    output logic                 o_sample_valid,
    output logic                 o_out_valid,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [NB_DEPTH:0]    o_sample_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Oldest stage of the valid pipe; it drives o_out_valid directly.
    localparam logic [FILTER_LAT-1:0] PIPE_TAIL = FILTER_LAT'(1) << (FILTER_LAT - 1);

    state_t                 state;
    state_t                 state_nxt;

    logic [NB_DEPTH:0]      n_lat;       // run length latched at start
    logic [NB_PERIOD-1:0]   p_lat;       // read period latched at start
    logic [NB_PERIOD-1:0]   p_eff;
    logic [NB_DEPTH:0]      rd_issued;   // reads issued so far in this run
    logic [NB_PERIOD-1:0]   wait_cnt;    // cycles left until the next read may issue
    logic                   rd_pend;     // ROM data for the previous read is on i_rom_* now
    logic [FILTER_LAT-1:0]  sv_pipe;

    logic                   start_ok;
    logic                   last_read_issued;
    logic                   read_now;
    logic                   drain_empty;

    assign p_eff            = (i_period == '0) ? NB_PERIOD'(1) : i_period;
    assign start_ok         = (state == S_IDLE) && i_start && !i_abort;
    assign last_read_issued = (rd_issued == n_lat);
    assign read_now         = (state == S_RUN) && (wait_cnt == '0) && !last_read_issued && !i_abort;
    assign o_out_valid      = sv_pipe[FILTER_LAT-1];

    // All reads are out when draining, so an output-valid with nothing behind
    // it in the ROM/strobe/valid pipe is the run's final filter output.
    assign drain_empty = o_out_valid && !rd_pend && !o_sample_valid
                         && ((sv_pipe & ~PIPE_TAIL) == '0);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_RUN;
            S_RUN:   if (i_abort) state_nxt = S_IDLE;
                     else if (last_read_issued) state_nxt = S_DRAIN;
            S_DRAIN: if (i_abort) state_nxt = S_IDLE;
                     else if (drain_empty) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (state)
            S_RUN, S_DRAIN: o_busy = 1'b1;
            S_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            n_lat          <= '0;
            p_lat          <= '0;
            rd_issued      <= '0;
            wait_cnt       <= '0;
            rd_pend        <= 1'b0;
            sv_pipe        <= '0;
            o_rom_en       <= 1'b0;
            o_rom_addr     <= '0;
            o_mic1         <= '0;
            o_mic2         <= '0;
            o_mu           <= '0;
            o_sample_valid <= 1'b0;
            o_sample_count <= '0;
        end else if (i_abort) begin
            // In-flight ROM data and pending valids are dropped; the last
            // presented sample, address and count stay visible.
            o_rom_en       <= 1'b0;
            rd_pend        <= 1'b0;
            o_sample_valid <= 1'b0;
            sv_pipe        <= '0;
        end else begin
            rd_pend        <= o_rom_en;
            o_sample_valid <= rd_pend;
            sv_pipe        <= (sv_pipe << 1) | FILTER_LAT'(o_sample_valid);

            if (rd_pend) begin
                o_mic1         <= i_rom_mic1;
                o_mic2         <= i_rom_mic2;
                o_mu           <= i_rom_mu;
                o_sample_count <= o_sample_count + 1'b1;
            end

            if (start_ok) begin
                // The first read goes out in the cycle right after start.
                n_lat          <= (i_num_samples == '0) ? {1'b1, {NB_DEPTH{1'b0}}}
                                                        : {1'b0, i_num_samples};
                p_lat          <= p_eff;
                wait_cnt       <= p_eff - NB_PERIOD'(1);
                rd_issued      <= (NB_DEPTH + 1)'(1);
                o_rom_en       <= 1'b1;
                o_rom_addr     <= '0;
                o_sample_count <= '0;
            end else if (read_now) begin
                o_rom_en   <= 1'b1;
                o_rom_addr <= rd_issued[NB_DEPTH-1:0];
                rd_issued  <= rd_issued + 1'b1;
                wait_cnt   <= p_lat - NB_PERIOD'(1);
            end else begin
                o_rom_en <= 1'b0;
                if ((state == S_RUN) && (wait_cnt != '0)) begin
                    wait_cnt <= wait_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// tb/tb_fir_sample_sequencer.sv - self-checking bench for fir_sample_sequencer

module tb_fir_sample_sequencer;

    localparam int NB_DATA  = 21;
    localparam int NB_DEPTH = 14;
    localparam int NB_PER   = 8;
    localparam int FL       = 3;
    localparam int DEPTH    = 16384;

    logic                tb_clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                abort;
    logic [NB_DEPTH-1:0] num_samples;
    logic [NB_PER-1:0]   period;
    logic                rom_en;
    logic [NB_DEPTH-1:0] rom_addr;
    logic [NB_DATA-1:0]  rom_mic1, rom_mic2, rom_mu;
    logic [NB_DATA-1:0]  mic1, mic2, mu;
    logic                sample_valid, out_valid, busy, done;
    logic [NB_DEPTH:0]   sample_count;

    logic [NB_DATA-1:0]  mic1_mem [DEPTH];
    logic [NB_DATA-1:0]  mic2_mem [DEPTH];
    logic [NB_DATA-1:0]  mu_mem   [DEPTH];
    logic [NB_DATA-1:0]  hold_m1, hold_m2, hold_mu;

    logic [96:0]         got_vec;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int n;
        int p;
        int abort_at;
        int glitch_at;
        int exp_done;
        int exp_cnt;
        int exp_addr;
    } vec_t;

    vec_t tbl [8];

    always #5 tb_clk = ~tb_clk;

    fir_sample_sequencer dut (
        .i_clk          (tb_clk),
        .i_rst          (rst_n),
        .i_start        (start),
        .i_abort        (abort),
        .i_num_samples  (num_samples),
        .i_period       (period),
        .o_rom_en       (rom_en),
        .o_rom_addr     (rom_addr),
        .i_rom_mic1     (rom_mic1),
        .i_rom_mic2     (rom_mic2),
        .i_rom_mu       (rom_mu),
        .o_mic1         (mic1),
        .o_mic2         (mic2),
        .o_mu           (mu),
        .o_sample_valid (sample_valid),
        .o_out_valid    (out_valid),
        .o_busy         (busy),
        .o_done         (done),
        .o_sample_count (sample_count)
    );

    // Synchronous ROMs with one-cycle read latency.
    always @(posedge tb_clk) begin
        if (rom_en) begin
            rom_mic1 <= mic1_mem[rom_addr];
            rom_mic2 <= mic2_mem[rom_addr];
            rom_mu   <= mu_mem[rom_addr];
        end
    end

    assign got_vec = {rom_en, rom_addr, sample_valid, out_valid, busy, done,
                      sample_count, mic1, mic2, mu};

    task automatic chk_vec(input string name, input int c, input logic [96:0] exp);
        n_vec++;
        if (got_vec !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, got_vec, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Expected outputs in cycle c of a run of n reads every p cycles, aborted
    // in cycle a (a < 0: no abort). Read k in cycle 1+k*p, strobe 2 later,
    // output-valid FL after that, done one cycle after the last output-valid.
    function automatic logic [96:0] model_vec(input int c, input int n, input int p, input int a);
        int d, ce, cnt, addr;
        logic ab, en, sv, ov, bz, dn;
        logic [NB_DATA-1:0] m1, m2, m3;
        d    = 3 + (n - 1) * p + FL + 1;
        ab   = (a >= 0) && (c > a);
        ce   = ab ? a : c;
        en   = !ab && ((c - 1) % p == 0) && ((c - 1) / p < n);
        addr = (ce - 1) / p;
        if (addr > n - 1) addr = n - 1;
        sv   = !ab && (c >= 3) && ((c - 3) % p == 0) && ((c - 3) / p < n);
        ov   = !ab && (c >= 3 + FL) && ((c - 3 - FL) % p == 0) && ((c - 3 - FL) / p < n);
        dn   = !ab && (c == d);
        bz   = !ab && (c <= d);
        cnt  = 0;
        if (ce >= 3) begin
            cnt = (ce - 3) / p + 1;
            if (cnt > n) cnt = n;
        end
        if (cnt > 0) begin
            m1 = mic1_mem[14'(cnt - 1)];
            m2 = mic2_mem[14'(cnt - 1)];
            m3 = mu_mem[14'(cnt - 1)];
        end else begin
            m1 = hold_m1;
            m2 = hold_m2;
            m3 = hold_mu;
        end
        return {en, 14'(addr), sv, ov, bz, dn, 15'(cnt), m1, m2, m3};
    endfunction

    // One run from the start cycle; i_num_samples/i_period are scrambled after
    // cycle 0, i_start is re-pulsed in cycle g and i_abort in cycle a.
    task automatic do_run(input int n_in, input int p_in, input int a, input int g,
                          output int done_cyc, output int fin_cnt, output int fin_addr);
        int n, p, d, last;
        logic [96:0] e;
        n    = (n_in == 0) ? DEPTH : n_in;
        p    = (p_in == 0) ? 1 : p_in;
        d    = 3 + (n - 1) * p + FL + 1;
        last = (a >= 0) ? a + 4 : d + 2;
        e    = '0;
        num_samples = 14'(n_in);
        period      = 8'(p_in);
        start       = 1'b1;
        abort       = 1'b0;
        @(posedge tb_clk); #1;
        start    = 1'b0;
        done_cyc = -1;
        for (int c = 1; c <= last; c++) begin
            num_samples = 14'($urandom);
            period      = 8'($urandom);
            start       = (c == g);
            abort       = (c == a);
            @(negedge tb_clk);
            e = model_vec(c, n, p, a);
            chk_vec("run", c, e);
            if (done) done_cyc = c;
            @(posedge tb_clk); #1;
        end
        start    = 1'b0;
        abort    = 1'b0;
        hold_m1  = e[62:42];
        hold_m2  = e[41:21];
        hold_mu  = e[20:0];
        fin_cnt  = int'(sample_count);
        fin_addr = int'(rom_addr);
    endtask

    initial begin
        int dc, fc, fa, n, p, d, a, g;

        for (int i = 0; i < DEPTH; i++) begin
            mic1_mem[i] = 21'($urandom);
            mic2_mem[i] = 21'($urandom);
            mu_mem[i]   = 21'($urandom);
        end
        hold_m1 = '0;
        hold_m2 = '0;
        hold_mu = '0;

        tbl[0] = '{4,   1, -1, -1, 10,    4,     3};
        tbl[1] = '{3,   4, -1,  5, 15,    3,     2};
        tbl[2] = '{0,   0, -1, -1, 16390, 16384, 16383};
        tbl[3] = '{100, 2, 20,  5, -1,    9,     9};
        tbl[4] = '{1,   1, -1, -1, 7,     1,     0};
        tbl[5] = '{2,   0, -1,  3, 8,     2,     1};
        tbl[6] = '{3, 255, -1,  2, 517,   3,     2};
        tbl[7] = '{2,   3,  4, -1, -1,    1,     1};

        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        num_samples = '0;
        period      = '0;
        #3;
        chk_vec("reset", 0, '0);
        repeat (2) @(posedge tb_clk);
        #1 rst_n = 1'b1;
        @(posedge tb_clk); #1;

        for (int i = 0; i < 8; i++) begin
            do_run(tbl[i].n, tbl[i].p, tbl[i].abort_at, tbl[i].glitch_at, dc, fc, fa);
            chk_int("done_cycle", dc, tbl[i].exp_done);
            chk_int("final_count", fc, tbl[i].exp_cnt);
            chk_int("final_addr", fa, tbl[i].exp_addr);
        end

        // Start and abort together in IDLE: no run begins.
        start = 1'b1;
        abort = 1'b1;
        @(posedge tb_clk); #1;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge tb_clk);
            chk_int("start_abort_idle", int'({busy, rom_en, sample_valid, out_valid}), 0);
            @(posedge tb_clk); #1;
        end

        // Asynchronous reset in the middle of a run.
        num_samples = 14'd10;
        period      = 8'd1;
        start       = 1'b1;
        @(posedge tb_clk); #1;
        start = 1'b0;
        repeat (3) @(posedge tb_clk);
        #3 rst_n = 1'b0;
        #1;
        chk_vec("async_reset", 4, '0);
        @(posedge tb_clk); #1;
        rst_n   = 1'b1;
        hold_m1 = '0;
        hold_m2 = '0;
        hold_mu = '0;
        do_run(4, 1, -1, -1, dc, fc, fa);
        chk_int("post_reset_done", dc, 10);
        chk_int("post_reset_count", fc, 4);

        // Randomized runs against the cycle model.
        for (int r = 0; r < 10; r++) begin
            n = int'($urandom_range(1, 12));
            p = int'($urandom_range(0, 4));
            d = 3 + (n - 1) * ((p == 0) ? 1 : p) + FL + 1;
            a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, d - 1)) : -1;
            g = int'($urandom_range(1, (a >= 0) ? a : d - 1));
            do_run(n, p, a, g, dc, fc, fa);
            chk_int("rand_done", dc, (a >= 0) ? -1 : d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
